// File: rtl/cgra_instr_loader.sv
// Loads the CGRA program image from HBM with one AXI-MM read burst and writes it into per-column imems.
// Latency: a beat accepted at cycle t writes lane k at cycle t+1+k; done pulses the cycle after the last write.
// Backpressure: rready drops while a phit is drained lane by lane. Build option: CGRA_LOADER_WFI_CHECK_EN (wfi check on last slot).
module cgra_instr_loader #(
    parameter int NUM_COLS      = 2,
    parameter int INSTR_PER_COL = 8,
    parameter int PHIT_W        = 512,
    parameter int INSTR_W       = 32,
    parameter int LANES         = 1,
    parameter int ADDR_W        = 64,
    // derived; leave at default
    parameter int IMEM_AW       = $clog2(INSTR_PER_COL)
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   m00_axi_araddr,
    output logic [7:0]          m00_axi_arlen,
    output logic                m00_axi_arvalid,
    input  logic                m00_axi_arready,
    input  logic [PHIT_W-1:0]   m00_axi_rdata,
    input  logic                m00_axi_rlast,
    input  logic                m00_axi_rvalid,
    output logic                m00_axi_rready,
    output logic [NUM_COLS-1:0] imem_we,
    output logic [IMEM_AW-1:0]  imem_waddr,
    output logic [INSTR_W-1:0]  imem_wdata
);

    localparam int BEATS = NUM_COLS * INSTR_PER_COL / LANES;
    localparam int BUF_W = LANES * INSTR_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int BW    = $clog2(BEATS + 1);
    localparam logic [LW-1:0]      LANE_LAST = LW'(LANES - 1);
    localparam logic [IMEM_AW-1:0] SLOT_LAST = IMEM_AW'(INSTR_PER_COL - 1);

    // The burst length field is 8 bits and every beat must carry whole lanes.
    if (BEATS > 256 || (NUM_COLS * INSTR_PER_COL) % LANES != 0 || LANES * INSTR_W > PHIT_W) begin : g_bad_cfg
        $error("cgra_instr_loader: illegal LANES/NUM_COLS/INSTR_PER_COL combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_AR, S_RD, S_DRAIN} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_araddr;
    logic [7:0]          r_arlen;
    logic                r_arvalid;
    logic                r_rready;
    logic [NUM_COLS-1:0] r_we;
    logic [IMEM_AW-1:0]  r_waddr;
    logic [INSTR_W-1:0]  r_wdata;
    logic [BUF_W-1:0]    r_buf;    // lanes not yet written, next lane in the LSBs
    logic [LW-1:0]       r_lane;   // lane currently on the write port
    logic [IMEM_AW-1:0]  r_slot;   // slot of the next instruction to write
    logic [CW-1:0]       r_col;    // column of the next instruction to write
    logic [BW-1:0]       r_beat;   // beats accepted so far

    logic                w_accept;
    logic                w_final_beat;
    logic                w_all_beats;
    logic [NUM_COLS-1:0] w_col_oh;
    logic [IMEM_AW-1:0]  w_slot_nxt;
    logic [CW-1:0]       w_col_nxt;
    logic [PHIT_W-1:0]   w_shift;
    logic                w_unused;

    // A beat is taken in RD, or on the last lane of DRAIN when the next one is already offered.
    assign w_accept     = m00_axi_rvalid && r_rready &&
                          ((r_state == S_RD) || (r_state == S_DRAIN && r_lane == LANE_LAST));
    assign w_final_beat = (r_beat == BW'(BEATS - 1));
    assign w_all_beats  = (r_beat == BW'(BEATS));
    assign w_col_oh     = NUM_COLS'(1) << r_col;
    assign w_slot_nxt   = (r_slot == SLOT_LAST) ? '0 : r_slot + IMEM_AW'(1);
    assign w_col_nxt    = (r_slot == SLOT_LAST) ? r_col + CW'(1) : r_col;
    assign w_shift      = m00_axi_rdata >> INSTR_W;
    // Phit bits above the used lanes are ignored by design.
    assign w_unused     = ^w_shift;

`ifdef CGRA_LOADER_WFI_CHECK_EN
    localparam logic [INSTR_W-1:0] WFI = INSTR_W'(32'h10500073);
`endif

    // Load FSM: address phase, beat accept, lane-by-lane drain; all outputs registered.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_we      <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_buf     <= '0;
            r_lane    <= '0;
            r_slot    <= '0;
            r_col     <= '0;
            r_beat    <= '0;
        end else begin
            r_we   <= '0;
            r_done <= 1'b0;
`ifdef CGRA_LOADER_WFI_CHECK_EN
            // The last slot of each column must hold wfi; flag it after the write lands.
            if (|r_we && r_waddr == SLOT_LAST && r_wdata != WFI) begin
                r_err <= 1'b1;
            end
`endif
            if (w_accept) begin
                if (m00_axi_rlast && !w_final_beat) begin
                    // Early rlast: burst is short, write nothing from it and abort.
                    r_err    <= 1'b1;
                    r_done   <= 1'b1;
                    r_rready <= 1'b0;
                    r_state  <= S_IDLE;
                end else begin
                    if (w_final_beat && !m00_axi_rlast) begin
                        r_err <= 1'b1;
                    end
                    r_we     <= w_col_oh;
                    r_waddr  <= r_slot;
                    r_wdata  <= m00_axi_rdata[INSTR_W-1:0];
                    r_buf    <= w_shift[BUF_W-1:0];
                    r_slot   <= w_slot_nxt;
                    r_col    <= w_col_nxt;
                    r_lane   <= '0;
                    r_beat   <= r_beat + BW'(1);
                    r_rready <= (LANES == 1) && !w_final_beat;
                    r_state  <= S_DRAIN;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                        if (start && !r_busy) begin
                            r_araddr  <= base_addr;
                            r_arlen   <= 8'(BEATS - 1);
                            r_arvalid <= 1'b1;
                            r_err     <= 1'b0;
                            r_busy    <= 1'b1;
                            r_slot    <= '0;
                            r_col     <= '0;
                            r_beat    <= '0;
                            r_lane    <= '0;
                            r_state   <= S_AR;
                        end
                    end
                    S_AR: begin
                        if (m00_axi_arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end
                    S_RD: begin
                        r_rready <= 1'b1;
                    end
                    S_DRAIN: begin
                        if (r_lane != LANE_LAST) begin
                            r_we     <= w_col_oh;
                            r_waddr  <= r_slot;
                            r_wdata  <= r_buf[INSTR_W-1:0];
                            r_buf    <= r_buf >> INSTR_W;
                            r_slot   <= w_slot_nxt;
                            r_col    <= w_col_nxt;
                            r_lane   <= r_lane + LW'(1);
                            // open rready for the last lane so the next beat can follow directly
                            r_rready <= (r_lane + LW'(1) == LANE_LAST) && !w_all_beats;
                        end else if (w_all_beats) begin
                            r_done   <= 1'b1;
                            r_rready <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_rready <= 1'b1;
                            r_state  <= S_RD;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign m00_axi_araddr  = r_araddr;
    assign m00_axi_arlen   = r_arlen;
    assign m00_axi_arvalid = r_arvalid;
    assign m00_axi_rready  = r_rready;
    assign imem_we         = r_we;
    assign imem_waddr      = r_waddr;
    assign imem_wdata      = r_wdata;

endmodule

// File: tb/tb_cgra_instr_loader.sv
// Directed bench for cgra_instr_loader: default 2-column/1-lane instance and a 4-column/4-lane instance.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: the read-data model holds rvalid and advances a beat only on an observed handshake.
module tb_cgra_instr_loader;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_chk = 0;
    int n_err = 0;

    // default instance
    logic         a_start, a_busy, a_done, a_err;
    logic [63:0]  a_base, a_araddr;
    logic [7:0]   a_arlen;
    logic         a_arvalid, a_arready, a_rlast, a_rvalid, a_rready;
    logic [511:0] a_rdata;
    logic [1:0]   a_we;
    logic [2:0]   a_waddr;
    logic [31:0]  a_wdata;

    // 4 columns, 4 lanes per phit
    logic         b_start, b_busy, b_done, b_err;
    logic [63:0]  b_base, b_araddr;
    logic [7:0]   b_arlen;
    logic         b_arvalid, b_arready, b_rlast, b_rvalid, b_rready;
    logic [511:0] b_rdata;
    logic [3:0]   b_we;
    logic [2:0]   b_waddr;
    logic [31:0]  b_wdata;

    cgra_instr_loader dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(a_start), .base_addr(a_base),
        .busy(a_busy), .done(a_done), .err(a_err),
        .m00_axi_araddr(a_araddr), .m00_axi_arlen(a_arlen), .m00_axi_arvalid(a_arvalid),
        .m00_axi_arready(a_arready), .m00_axi_rdata(a_rdata), .m00_axi_rlast(a_rlast),
        .m00_axi_rvalid(a_rvalid), .m00_axi_rready(a_rready),
        .imem_we(a_we), .imem_waddr(a_waddr), .imem_wdata(a_wdata)
    );

    cgra_instr_loader #(.NUM_COLS(4), .LANES(4)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(b_start), .base_addr(b_base),
        .busy(b_busy), .done(b_done), .err(b_err),
        .m00_axi_araddr(b_araddr), .m00_axi_arlen(b_arlen), .m00_axi_arvalid(b_arvalid),
        .m00_axi_arready(b_arready), .m00_axi_rdata(b_rdata), .m00_axi_rlast(b_rlast),
        .m00_axi_rvalid(b_rvalid), .m00_axi_rready(b_rready),
        .imem_we(b_we), .imem_waddr(b_waddr), .imem_wdata(b_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // column program: vsetivli, lui, addi, addi, add, nop, nop, wfi
    function automatic logic [31:0] inst_a(input int n, input bit nop7);
        if (nop7 && n == 15) return 32'h00000013;
        case (n % 8)
            0:       return 32'hcd027057;
            1:       return 32'h000102b7;
            2:       return 32'h00128293;
            3:       return 32'h00230313;
            4:       return 32'h006283b3;
            5:       return 32'h00000013;
            6:       return 32'h00000013;
            default: return 32'h10500073;
        endcase
    endfunction

    function automatic logic [31:0] inst_b(input int n);
        if (n % 8 == 7) return 32'h10500073;
        return 32'hb0000000 + 32'(n);
    endfunction

    // unused lanes carry junk so lane-select mistakes show up
    function automatic logic [511:0] phit_a(input int beat, input bit nop7);
        logic [511:0] p;
        for (int k = 0; k < 16; k++) p[k*32 +: 32] = 32'hdead0000 | 32'(k);
        p[31:0] = inst_a(beat, nop7);
        return p;
    endfunction

    function automatic logic [511:0] phit_b(input int beat);
        logic [511:0] p;
        for (int k = 0; k < 16; k++) p[k*32 +: 32] = 32'hdead0000 | 32'(k);
        for (int k = 0; k < 4; k++) p[k*32 +: 32] = inst_b(4 * beat + k);
        return p;
    endfunction

    int   res_nw, res_first, res_last, res_done;
    bit   res_saw;
    logic res_err, res_busy, res_rr;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // One load on the default instance. bad_beat: beat index carrying an early rlast (-1 none).
    // rst_at: assert reset right after this many writes (-1 none).
    task automatic run_a(input int bad_beat, input int rst_at, input bit nop7);
        int beat;
        bit hs;
        res_nw = 0; res_first = -1; res_last = -1; res_done = -1; res_saw = 0;
        res_err = 1'b0; res_busy = 1'b0; res_rr = 1'b0;
        a_base = 64'h1000;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("busy_after_start", a_busy, 1);
        chk("err_cleared", a_err, 0);
        // arready low for 5 cycles; a second start mid-way must be ignored
        for (int i = 0; i < 5; i++) begin
            chk("arvalid_hold", a_arvalid, 1);
            chk("araddr", a_araddr, 64'h1000);
            chk("arlen", a_arlen, 15);
            if (i == 1) begin a_start = 1'b1; a_base = 64'h2000; end
            else        begin a_start = 1'b0; a_base = 64'h1000; end
            tick();
        end
        a_arready = 1'b1;
        chk("arvalid_at_hs", a_arvalid, 1);
        tick();
        a_arready = 1'b0;
        chk("arvalid_drop", a_arvalid, 0);
        chk("rready_rd", a_rready, 1);
        beat = 0;
        a_rvalid = 1'b1;
        a_rdata = phit_a(0, nop7);
        a_rlast = (bad_beat == 0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (a_we != 0) begin
                chk("write_a", {a_we, a_waddr, a_wdata},
                    {2'(1 << (res_nw / 8)), 3'(res_nw % 8), inst_a(res_nw, nop7)});
                if (res_first < 0) res_first = cyc;
                res_last = cyc;
                res_nw++;
                if (rst_at >= 0 && res_nw == rst_at) begin
                    ap_rst_n = 1'b0;
                    #1;
                    chk("rst_we", a_we, 0);
                    chk("rst_busy", a_busy, 0);
                    chk("rst_rready", a_rready, 0);
                    a_rvalid = 1'b0;
                    a_rlast = 1'b0;
                    tick();
                    ap_rst_n = 1'b1;
                    tick();
                    return;
                end
            end
            if (a_done) begin
                res_saw = 1; res_done = cyc; res_err = a_err; res_busy = a_busy; res_rr = a_rready;
                break;
            end
            hs = a_rvalid && a_rready;
            tick();
            if (hs) begin
                beat++;
                a_rdata = phit_a(beat, nop7);
                a_rlast = (beat == 15) || (beat == bad_beat);
            end
        end
        a_rvalid = 1'b0;
        a_rlast = 1'b0;
        chk("done_seen", res_saw, 1);
        chk("busy_in_done", res_busy, 1);
        chk("rready_in_done", res_rr, 0);
        chk("done_after_last_write", res_done, res_last + 1);
        tick();
        chk("busy_drop", a_busy, 0);
        chk("done_one_cycle", a_done, 0);
        chk("rready_idle", a_rready, 0);
    endtask

    task automatic run_b();
        int beat, nw, first, last;
        bit hs, saw;
        nw = 0; first = -1; last = -1; saw = 0; beat = 0;
        b_base = 64'h4000;
        b_arready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_arvalid", b_arvalid, 1);
        chk("b_arlen", b_arlen, 7);
        chk("b_araddr", b_araddr, 64'h4000);
        tick();
        b_arready = 1'b0;
        chk("b_rready_rd", b_rready, 1);
        b_rvalid = 1'b1;
        b_rdata = phit_b(0);
        b_rlast = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (b_we != 0) begin
                chk("write_b", {b_we, b_waddr, b_wdata},
                    {4'(1 << (nw / 8)), 3'(nw % 8), inst_b(nw)});
                chk("b_rready_lane", b_rready, (nw % 4 == 3) && (nw / 4 < 7));
                if (first < 0) first = cyc;
                last = cyc;
                nw++;
            end
            if (b_done) begin
                saw = 1;
                chk("b_done_after_last_write", cyc, last + 1);
                chk("b_err", b_err, 0);
                break;
            end
            hs = b_rvalid && b_rready;
            tick();
            if (hs) begin
                beat++;
                b_rdata = phit_b(beat);
                b_rlast = (beat == 7);
            end
        end
        b_rvalid = 1'b0;
        chk("b_done_seen", saw, 1);
        chk("b_writes", nw, 32);
        chk("b_back_to_back", last - first, 31);
        tick();
        chk("b_busy_drop", b_busy, 0);
    endtask

    initial begin
        logic exp_wfi_err;
        a_start = 1'b0; a_base = '0; a_arready = 1'b0; a_rdata = '0; a_rlast = 1'b0; a_rvalid = 1'b0;
        b_start = 1'b0; b_base = '0; b_arready = 1'b0; b_rdata = '0; b_rlast = 1'b0; b_rvalid = 1'b0;
        ap_rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_arvalid", a_arvalid, 0);
        chk("rst_rready", a_rready, 0);
        chk("rst_we", a_we, 0);
        chk("rst_araddr", a_araddr, 0);
        chk("rst_arlen", a_arlen, 0);
        chk("rst_waddr_wdata", {a_waddr, a_wdata}, 0);
        chk("rst_b_we", b_we, 0);
        ap_rst_n = 1'b1;
        tick();

        // full image, rvalid held
        run_a(-1, -1, 1'b0);
        chk("full_writes", res_nw, 16);
        chk("full_back_to_back", res_last - res_first, 15);
        chk("full_err", res_err, 0);

        // early rlast on beat 3
        run_a(3, -1, 1'b0);
        chk("rlast_writes", res_nw, 3);
        chk("rlast_err", res_err, 1);

        // reset in the middle of the drain, then reload from column 0 slot 0
        run_a(-1, 5, 1'b0);
        chk("rst_mid_writes", res_nw, 5);
        run_a(-1, -1, 1'b0);
        chk("reload_writes", res_nw, 16);
        chk("reload_err", res_err, 0);

        // nop in column 1 slot 7
`ifdef CGRA_LOADER_WFI_CHECK_EN
        exp_wfi_err = 1'b1;
`else
        exp_wfi_err = 1'b0;
`endif
        run_a(-1, -1, 1'b1);
        chk("nop7_writes", res_nw, 16);
        chk("nop7_err", res_err, exp_wfi_err);

        run_b();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
